prom_loader: RTL and testbench

Frame-based program loader that sits between the UART receiver and the instruction PROM. It parses a length-prefixed byte stream into 16-bit little-endian words and writes them to consecutive PROM addresses from 0. It holds the CPU in reset until a complete, valid frame has been stored, and reports framing, overrun and timeout faults. With the checksum feature compiled in, it also reports checksum faults.

---
 rtl/prom_loader.sv | 157 +++++++++++++++
 tb/tb_prom_loader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prom_loader.sv
// Parses a length-prefixed UART byte stream into 16-bit little-endian words and writes them to PROM from address 0,
// holding the CPU in reset until a full frame is stored. Optional checksum byte: PROM_LOADER_CHECKSUM_EN.
module prom_loader #(
    parameter int ROM_WORDS      = 42,
    parameter int TIMEOUT_CYCLES = 25000,
    localparam int AW            = $clog2(ROM_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    rx_data_i,
    input  logic          rx_ready_i,
    output logic [AW-1:0] prom_addr_o,
    output logic [15:0]   prom_data_o,
    output logic          prom_we_o,
    output logic          cpu_reset_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          error_o
);

    localparam int RW = $clog2(ROM_WORDS + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [31:0] ROM_WORDS_U = ROM_WORDS;

    typedef enum logic [2:0] {
        WAIT_COUNT,
        RX_LOW,
        RX_HIGH,
        WRITE,
        RX_SUM,
        DONE,
        ERROR
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   prom_addr_q;
    logic [15:0]     prom_data_q;
    logic            prom_we_q;
    logic            cpu_reset_q;
    logic            busy_q;
    logic            done_q;
    logic            error_q;
    logic [RW-1:0]   rem_q;
    logic [TW-1:0]   tmo_q;
    logic            tmo_expired;
    logic            waiting_byte;
    logic            count_bad;
`ifdef PROM_LOADER_CHECKSUM_EN
    logic [7:0]      sum_q;
`endif

    assign tmo_expired  = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    assign waiting_byte = (state_q == RX_LOW) || (state_q == RX_HIGH) || (state_q == RX_SUM);
    assign count_bad    = (rx_data_i == 8'h00) || ({24'b0, rx_data_i} > ROM_WORDS_U);

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_COUNT: if (rx_ready_i) state_d = count_bad ? ERROR : RX_LOW;
            RX_LOW: begin
                if (rx_ready_i)       state_d = RX_HIGH;
                else if (tmo_expired) state_d = ERROR;
            end
            RX_HIGH: begin
                if (rx_ready_i)       state_d = WRITE;
                else if (tmo_expired) state_d = ERROR;
            end
            WRITE: begin
                // A byte landing during the write cycle cannot be buffered: overrun.
                if (rx_ready_i)
                    state_d = ERROR;
                else if (rem_q == RW'(1))
`ifdef PROM_LOADER_CHECKSUM_EN
                    state_d = RX_SUM;
`else
                    state_d = DONE;
`endif
                else
                    state_d = RX_LOW;
            end
`ifdef PROM_LOADER_CHECKSUM_EN
            RX_SUM: begin
                if (rx_ready_i)       state_d = (8'(sum_q + rx_data_i) == 8'h00) ? DONE : ERROR;
                else if (tmo_expired) state_d = ERROR;
            end
`endif
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= WAIT_COUNT;
            prom_addr_q <= '0;
            prom_data_q <= '0;
            prom_we_q   <= 1'b0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            rem_q       <= '0;
            tmo_q       <= '0;
`ifdef PROM_LOADER_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            prom_we_q   <= (state_d == WRITE);
            busy_q      <= (state_d == RX_LOW) || (state_d == RX_HIGH) ||
                           (state_d == WRITE)  || (state_d == RX_SUM);
            done_q      <= (state_d == DONE);
            error_q     <= (state_d == ERROR);
            cpu_reset_q <= (state_d != DONE);

            if (waiting_byte && !rx_ready_i && !tmo_expired)
                tmo_q <= tmo_q + TW'(1);
            else
                tmo_q <= '0;

            case (state_q)
                WAIT_COUNT: if (rx_ready_i && !count_bad) begin
                    rem_q       <= RW'(rx_data_i);
                    prom_addr_q <= '0;
`ifdef PROM_LOADER_CHECKSUM_EN
                    sum_q       <= rx_data_i;
`endif
                end
                RX_LOW: if (rx_ready_i) begin
                    prom_data_q[7:0] <= rx_data_i;
`ifdef PROM_LOADER_CHECKSUM_EN
                    sum_q            <= sum_q + rx_data_i;
`endif
                end
                RX_HIGH: if (rx_ready_i) begin
                    prom_data_q[15:8] <= rx_data_i;
`ifdef PROM_LOADER_CHECKSUM_EN
                    sum_q             <= sum_q + rx_data_i;
`endif
                end
                WRITE: begin
                    rem_q <= rem_q - RW'(1);
                    if (state_d == RX_LOW) prom_addr_q <= prom_addr_q + AW'(1);
                end
                default: ;
            endcase
        end
    end

    assign prom_addr_o = prom_addr_q;
    assign prom_data_o = prom_data_q;
    assign prom_we_o   = prom_we_q;
    assign cpu_reset_o = cpu_reset_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign error_o     = error_q;

endmodule

// File: tb/tb_prom_loader.sv
// Directed bench for prom_loader: vector table for the basic frame, hand sequences for faults, reset and a full-depth load.
module tb_prom_loader;

    localparam int ROM_WORDS = 42;
    localparam int TMO       = 8;
    localparam int AW        = $clog2(ROM_WORDS);

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    rx_data_i;
    logic          rx_ready_i;
    logic [AW-1:0] prom_addr_o;
    logic [15:0]   prom_data_o;
    logic          prom_we_o;
    logic          cpu_reset_o;
    logic          busy_o;
    logic          done_o;
    logic          error_o;

    int total = 0;
    int bad   = 0;

    logic [15:0]   mem [0:63];
    int            we_cnt = 0;
    logic [AW-1:0] addr_log [$];

    prom_loader #(.ROM_WORDS(ROM_WORDS), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data_i  (rx_data_i),
        .rx_ready_i (rx_ready_i),
        .prom_addr_o(prom_addr_o),
        .prom_data_o(prom_data_o),
        .prom_we_o  (prom_we_o),
        .cpu_reset_o(cpu_reset_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .error_o    (error_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (prom_we_o) begin
            mem[prom_addr_o] <= prom_data_o;
            we_cnt <= we_cnt + 1;
            addr_log.push_back(prom_addr_o);
        end
    end

    typedef struct {
        logic          rdy;
        logic [7:0]    b;
        logic          we;
        logic [AW-1:0] addr;
        logic [15:0]   data;
        logic          busy;
        logic          done;
        logic          err;
        logic          cpurst;
    } vec_t;

    vec_t vt [12];
    int   nv;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; rx_ready_i = 1'b0; rx_data_i = 8'h00;
        tick();
        reset = 1'b0;
    endtask

    // One byte strobe followed by one idle cycle (minimum legal spacing).
    task automatic send(input logic [7:0] b);
        rx_ready_i = 1'b1; rx_data_i = b;
        tick();
        rx_ready_i = 1'b0; rx_data_i = 8'h00;
        tick();
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, "_addr"},   32'(prom_addr_o), 32'h0);
        chk({tag, "_data"},   32'(prom_data_o), 32'h0);
        chk({tag, "_we"},     32'(prom_we_o),   32'h0);
        chk({tag, "_cpurst"}, 32'(cpu_reset_o), 32'h1);
        chk({tag, "_busy"},   32'(busy_o),      32'h0);
        chk({tag, "_done"},   32'(done_o),      32'h0);
        chk({tag, "_err"},    32'(error_o),     32'h0);
    endtask

    initial begin
        int w0;
        logic [7:0] sum;
        logic [7:0] lo, hi;
        int base;

        reset = 1'b1; rx_ready_i = 1'b0; rx_data_i = 8'h00;
        tick(); tick();
        reset = 1'b0;
        chk_idle_reset("rst");

        // Basic frame 02 | 34 12 | 78 56 (checksum EA when enabled: 02+34+12+78+56 = 0x116)
        vt[0] = '{1'b1, 8'h02, 1'b0, 6'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[1] = '{1'b1, 8'h34, 1'b0, 6'd0, 16'h0034, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[2] = '{1'b0, 8'h00, 1'b0, 6'd0, 16'h0034, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[3] = '{1'b1, 8'h12, 1'b1, 6'd0, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[4] = '{1'b0, 8'h00, 1'b0, 6'd1, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[5] = '{1'b1, 8'h78, 1'b0, 6'd1, 16'h1278, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[6] = '{1'b1, 8'h56, 1'b1, 6'd1, 16'h5678, 1'b1, 1'b0, 1'b0, 1'b1};
`ifdef PROM_LOADER_CHECKSUM_EN
        vt[7] = '{1'b0, 8'h00, 1'b0, 6'd1, 16'h5678, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[8] = '{1'b1, 8'hEA, 1'b0, 6'd1, 16'h5678, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[9] = '{1'b1, 8'hFF, 1'b0, 6'd1, 16'h5678, 1'b0, 1'b1, 1'b0, 1'b0};
        nv = 10;
`else
        vt[7] = '{1'b0, 8'h00, 1'b0, 6'd1, 16'h5678, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[8] = '{1'b1, 8'hFF, 1'b0, 6'd1, 16'h5678, 1'b0, 1'b1, 1'b0, 1'b0};
        nv = 9;
`endif
        w0 = we_cnt;
        for (int i = 0; i < nv; i++) begin
            rx_ready_i = vt[i].rdy; rx_data_i = vt[i].b;
            tick();
            chk($sformatf("v%0d_we", i),     32'(prom_we_o),   32'(vt[i].we));
            chk($sformatf("v%0d_addr", i),   32'(prom_addr_o), 32'(vt[i].addr));
            chk($sformatf("v%0d_data", i),   32'(prom_data_o), 32'(vt[i].data));
            chk($sformatf("v%0d_busy", i),   32'(busy_o),      32'(vt[i].busy));
            chk($sformatf("v%0d_done", i),   32'(done_o),      32'(vt[i].done));
            chk($sformatf("v%0d_err", i),    32'(error_o),     32'(vt[i].err));
            chk($sformatf("v%0d_cpurst", i), 32'(cpu_reset_o), 32'(vt[i].cpurst));
        end
        rx_ready_i = 1'b0;
        tick();
        chk("frame_mem0", 32'(mem[0]), 32'h1234);
        chk("frame_mem1", 32'(mem[1]), 32'h5678);
        chk("frame_wes",  32'(we_cnt - w0), 32'd2);

`ifdef PROM_LOADER_CHECKSUM_EN
        do_reset();
        w0 = we_cnt;
        send(8'h02); send(8'h34); send(8'h12); send(8'h78); send(8'h56); send(8'hEB);
        chk("badsum_wes",    32'(we_cnt - w0), 32'd2);
        chk("badsum_err",    32'(error_o),     32'h1);
        chk("badsum_done",   32'(done_o),      32'h0);
        chk("badsum_cpurst", 32'(cpu_reset_o), 32'h1);
`endif

        // Illegal count bytes
        do_reset();
        w0 = we_cnt;
        rx_ready_i = 1'b1; rx_data_i = 8'h00;
        tick();
        rx_ready_i = 1'b0;
        chk("cnt0_err",    32'(error_o),     32'h1);
        chk("cnt0_cpurst", 32'(cpu_reset_o), 32'h1);
        chk("cnt0_busy",   32'(busy_o),      32'h0);
        send(8'h01); send(8'h11); send(8'h22);
        chk("cnt0_sticky", 32'(error_o), 32'h1);
        do_reset();
        rx_ready_i = 1'b1; rx_data_i = 8'(ROM_WORDS + 1);
        tick();
        rx_ready_i = 1'b0;
        chk("cnt43_err", 32'(error_o), 32'h1);
        chk("cnt_wes",   32'(we_cnt - w0), 32'd0);

        // Timeout: error exactly TMO edges after the AA strobe
        do_reset();
        w0 = we_cnt;
        send(8'h01);
        rx_ready_i = 1'b1; rx_data_i = 8'hAA;
        tick();
        rx_ready_i = 1'b0;
        repeat (TMO - 1) tick();
        chk("tmo_early_err", 32'(error_o), 32'h0);
        chk("tmo_early_busy", 32'(busy_o), 32'h1);
        tick();
        chk("tmo_err",  32'(error_o),     32'h1);
        chk("tmo_busy", 32'(busy_o),      32'h0);
        chk("tmo_wes",  32'(we_cnt - w0), 32'd0);

        // Overrun: strobe during the WRITE cycle
        do_reset();
        w0 = we_cnt;
        rx_ready_i = 1'b1;
        rx_data_i = 8'h02; tick();
        rx_data_i = 8'h11; tick();
        rx_data_i = 8'h22; tick();
        chk("ovr_we", 32'(prom_we_o), 32'h1);
        rx_data_i = 8'h33; tick();
        rx_ready_i = 1'b0;
        chk("ovr_err", 32'(error_o), 32'h1);
        send(8'h44); send(8'h55); send(8'h66);
        chk("ovr_wes",  32'(we_cnt - w0), 32'd1);
        chk("ovr_done", 32'(done_o),      32'h0);

        // Reset mid-frame, then a fresh one-word frame
        do_reset();
        send(8'h03); send(8'h01); send(8'h02);
        rx_ready_i = 1'b1; rx_data_i = 8'h03; tick();
        rx_ready_i = 1'b0;
        chk("mid_busy", 32'(busy_o), 32'h1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk_idle_reset("mid");
        w0 = we_cnt;
        send(8'h01); send(8'hCD); send(8'hAB);
`ifdef PROM_LOADER_CHECKSUM_EN
        send(8'h87);
`endif
        chk("fresh_done",   32'(done_o),      32'h1);
        chk("fresh_cpurst", 32'(cpu_reset_o), 32'h0);
        chk("fresh_mem0",   32'(mem[0]),      32'hABCD);
        chk("fresh_wes",    32'(we_cnt - w0), 32'd1);

        // Full-depth frame
        do_reset();
        base = addr_log.size();
        sum = 8'(ROM_WORDS);
        send(8'(ROM_WORDS));
        for (int i = 0; i < ROM_WORDS; i++) begin
            lo = 8'(i * 3);
            hi = 8'(255 - i);
            sum = sum + lo + hi;
            send(lo);
            if (i < ROM_WORDS - 1) begin
                send(hi);
            end else begin
                rx_ready_i = 1'b1; rx_data_i = hi; tick();
                rx_ready_i = 1'b0;
                chk("full_last_we",   32'(prom_we_o),   32'h1);
                chk("full_last_addr", 32'(prom_addr_o), 32'(ROM_WORDS - 1));
                chk("full_last_done", 32'(done_o),      32'h0);
                tick();
`ifdef PROM_LOADER_CHECKSUM_EN
                chk("full_sum_busy", 32'(busy_o), 32'h1);
                send(8'(-sum));
`endif
                chk("full_done",   32'(done_o),      32'h1);
                chk("full_cpurst", 32'(cpu_reset_o), 32'h0);
                chk("full_err",    32'(error_o),     32'h0);
            end
        end
        chk("full_nwrites", 32'(addr_log.size() - base), 32'(ROM_WORDS));
        for (int i = 0; i < ROM_WORDS; i++) begin
            chk($sformatf("full_addr%0d", i), 32'(addr_log[base + i]), 32'(i));
            chk($sformatf("full_mem%0d", i),  32'(mem[i]), 32'({8'(255 - i), 8'(i * 3)}));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
